// File: rtl/mul_div_pkg.sv
// Shared types and constants for the multi-cycle signed multiply/divide engine.
package mul_div_pkg;

   localparam int ITERS = 32;

   localparam logic OP_MUL = 1'b0;
   localparam logic OP_DIV = 1'b1;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      FIX  = 2'd2,
      DONE = 2'd3
   } state_t;

endpackage

// File: rtl/addsub_33.sv
// Guard-bit add/subtract shared by the Booth step and the restoring-divide trial subtract.
module addsub_33 #(
   parameter int W = 33
) (
   input  logic [W-1:0] x,
   input  logic [W-1:0] y,
   input  logic         sub,
   output logic [W-1:0] sum
);

   assign sum = sub ? (x - y) : (x + y);

endmodule

// File: rtl/mul_div_unit.sv
// Multi-cycle signed multiply (radix-2 Booth) / divide (restoring on magnitudes) engine.
// One iteration per clock, followed by a sign-fix cycle and a one-cycle done pulse.
module mul_div_unit
   import mul_div_pkg::*;
#(
   parameter int WIDTH = ITERS
) (
   input  logic             clk,
   input  logic             clr,
   input  logic             start,
   input  logic             op,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             busy,
   output logic             done,
   output logic             div_by_zero,
   output logic [WIDTH-1:0] hi_out,
   output logic [WIDTH-1:0] lo_out
);

   localparam int CW = $clog2(WIDTH);

   state_t           state, state_nxt;
   logic             op_r;
   logic             neg_q;
   logic             neg_r;
   logic             q_1;
   logic [WIDTH:0]   acc;
   logic [WIDTH:0]   mcand;
   logic [WIDTH-1:0] mq;
   logic [CW-1:0]    cnt;

   logic             last_iter;
   logic             dbz_run;
   logic [WIDTH:0]   div_shift;
   logic [WIDTH:0]   as_x;
   logic             as_sub;
   logic [WIDTH:0]   as_sum;
   logic [WIDTH:0]   booth_acc;

   function automatic logic [WIDTH-1:0] mag(input logic [WIDTH-1:0] v);
      return v[WIDTH-1] ? -v : v;
   endfunction

   // acc doubles as the Booth accumulator and the divide partial remainder;
   // mq holds the multiplier (shifting out) or the dividend/quotient (shifting in).
   assign last_iter = (cnt == CW'(WIDTH - 1));
   assign dbz_run   = (op_r == OP_DIV) && (mcand == '0);
   assign div_shift = {acc[WIDTH-1:0], mq[WIDTH-1]};
   assign as_x      = (op_r == OP_DIV) ? div_shift : acc;
   assign as_sub    = (op_r == OP_DIV) | (mq[0] & ~q_1);
   assign booth_acc = (mq[0] ^ q_1) ? as_sum : acc;

   addsub_33 #(.W(WIDTH + 1)) u_addsub (
      .x   (as_x),
      .y   (mcand),
      .sub (as_sub),
      .sum (as_sum)
   );

   assign busy = (state == RUN) || (state == FIX);
   assign done = (state == DONE);

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples pre-edge values regardless of statement order.
   always_ff @(posedge clk or negedge clr) begin
      if (!clr) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // NOTE: state_nxt gets a default before the case so no path leaves it
   // unassigned, which would otherwise infer a latch.
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE: if (start) state_nxt = RUN;
         RUN: begin
            if (dbz_run)        state_nxt = DONE;
            else if (last_iter) state_nxt = FIX;
         end
         FIX:     state_nxt = DONE;
         DONE:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // NOTE: every datapath register is reset, so an aborted operation leaves
   // no stale operands or results behind.
   always_ff @(posedge clk or negedge clr) begin
      if (!clr) begin
         op_r        <= OP_MUL;
         neg_q       <= 1'b0;
         neg_r       <= 1'b0;
         q_1         <= 1'b0;
         acc         <= '0;
         mcand       <= '0;
         mq          <= '0;
         cnt         <= '0;
         div_by_zero <= 1'b0;
         hi_out      <= '0;
         lo_out      <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (start) begin
                  op_r        <= op;
                  cnt         <= '0;
                  acc         <= '0;
                  q_1         <= 1'b0;
                  div_by_zero <= 1'b0;
                  if (op == OP_DIV) begin
                     mcand <= {1'b0, mag(b)};
                     mq    <= mag(a);
                     neg_q <= a[WIDTH-1] ^ b[WIDTH-1];
                     neg_r <= a[WIDTH-1];
                  end else begin
                     mcand <= {a[WIDTH-1], a};
                     mq    <= b;
                     neg_q <= 1'b0;
                     neg_r <= 1'b0;
                  end
               end
            end
            RUN: begin
               if (dbz_run) begin
                  // Re-signing |a| recovers the original dividend bit pattern.
                  hi_out      <= neg_r ? -mq : mq;
                  lo_out      <= '1;
                  div_by_zero <= 1'b1;
               end else begin
                  cnt <= cnt + 1'b1;
                  if (op_r == OP_MUL) begin
                     acc <= {booth_acc[WIDTH], booth_acc[WIDTH:1]};
                     mq  <= {booth_acc[0], mq[WIDTH-1:1]};
                     q_1 <= mq[0];
                  end else begin
                     acc <= as_sum[WIDTH] ? div_shift : as_sum;
                     mq  <= {mq[WIDTH-2:0], ~as_sum[WIDTH]};
                  end
               end
            end
            FIX: begin
               if (op_r == OP_MUL) begin
                  {hi_out, lo_out} <= {acc[WIDTH-1:0], mq};
               end else begin
                  lo_out <= neg_q ? -mq : mq;
                  hi_out <= neg_r ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_mul_div_unit.sv
// Directed self-checking bench for mul_div_unit: latency, busy window, signed results,
// divide-by-zero, overflow wrap, start during RUN, and asynchronous abort.
module tb_mul_div_unit;
   import mul_div_pkg::*;

   logic        clk;
   logic        clr;
   logic        start;
   logic        op;
   logic [31:0] a;
   logic [31:0] b;
   logic        busy;
   logic        done;
   logic        div_by_zero;
   logic [31:0] hi_out;
   logic [31:0] lo_out;

   int total = 0;
   int bad   = 0;
   int done_pulses = 0;

   int   lat;
   int   busy_cnt;
   logic dbz0;
   int   pulses_before;

   mul_div_unit #(.WIDTH(32)) dut (
      .clk         (clk),
      .clr         (clr),
      .start       (start),
      .op          (op),
      .a           (a),
      .b           (b),
      .busy        (busy),
      .done        (done),
      .div_by_zero (div_by_zero),
      .hi_out      (hi_out),
      .lo_out      (lo_out)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(negedge clk) if (done) done_pulses++;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      assert (obs === exp)
      else begin
         bad++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Issues one operation and samples on falling edges; k counts rising edges after E0.
   task automatic run_op(input logic o, input logic [31:0] x, input logic [31:0] y,
                         input bit poke, output int lat_o, output int busy_o,
                         output logic dbz_o);
      bit seen;
      @(negedge clk);
      start = 1'b1; op = o; a = x; b = y;
      @(negedge clk);
      start = 1'b0;
      lat_o  = -1;
      busy_o = 0;
      dbz_o  = div_by_zero;
      seen   = 0;
      for (int k = 0; k < 100; k++) begin
         if (k > 0) @(negedge clk);
         if (done) begin
            lat_o = k;
            seen  = 1;
         end else if (busy) begin
            busy_o++;
         end
         if (poke && k == 5) begin
            start = 1'b1; op = ~o; a = 32'd3; b = 32'd1;
         end
         if (poke && k == 6) start = 1'b0;
         if (seen) break;
      end
      start = 1'b0;
      @(negedge clk);
      check("done_one_cycle", 64'(done), 64'd0);
      check("idle_after_done", 64'(busy), 64'd0);
   endtask

   initial begin
      clr = 1'b0; start = 1'b0; op = 1'b0; a = '0; b = '0;
      #12;
      check("rst_busy", 64'(busy), 64'd0);
      check("rst_done", 64'(done), 64'd0);
      check("rst_dbz",  64'(div_by_zero), 64'd0);
      check("rst_hilo", {hi_out, lo_out}, 64'd0);
      @(negedge clk);
      clr = 1'b1;

      // 7 * -3 = -21
      pulses_before = done_pulses;
      run_op(OP_MUL, 32'd7, 32'hFFFF_FFFD, 0, lat, busy_cnt, dbz0);
      check("mul_7_m3_lat",  64'(lat), 64'd33);
      check("mul_7_m3_busy", 64'(busy_cnt), 64'd33);
      check("mul_7_m3_hi",   64'(hi_out), 64'h0000_0000_FFFF_FFFF);
      check("mul_7_m3_lo",   64'(lo_out), 64'h0000_0000_FFFF_FFEB);
      check("mul_7_m3_dbz",  64'(div_by_zero), 64'd0);
      check("mul_7_m3_pulses", 64'(done_pulses - pulses_before), 64'd1);

      // Abort mid-RUN with clr low at E10
      pulses_before = done_pulses;
      @(negedge clk);
      start = 1'b1; op = OP_MUL; a = 32'd5; b = 32'd5;
      @(negedge clk);
      start = 1'b0;
      repeat (9) @(negedge clk);
      @(posedge clk);
      #1 clr = 1'b0;
      #1;
      check("abort_busy", 64'(busy), 64'd0);
      check("abort_done", 64'(done), 64'd0);
      check("abort_hilo", {hi_out, lo_out}, 64'd0);
      repeat (3) @(negedge clk);
      clr = 1'b1;
      #1;
      check("abort_state", 64'(dut.state), 64'(IDLE));
      repeat (40) @(negedge clk);
      check("abort_no_done", 64'(done_pulses - pulses_before), 64'd0);
      check("abort_hilo_held", {hi_out, lo_out}, 64'd0);

      // Fresh operation after abort
      run_op(OP_MUL, 32'd5, 32'd5, 0, lat, busy_cnt, dbz0);
      check("mul_5_5_lat",  64'(lat), 64'd33);
      check("mul_5_5_prod", {hi_out, lo_out}, 64'd25);

      // (-2^31) * (-2^31) = 2^62
      run_op(OP_MUL, 32'h8000_0000, 32'h8000_0000, 0, lat, busy_cnt, dbz0);
      check("mul_min_min", {hi_out, lo_out}, 64'h4000_0000_0000_0000);

      // -17 / 5 = -3 rem -2
      run_op(OP_DIV, 32'hFFFF_FFEF, 32'd5, 0, lat, busy_cnt, dbz0);
      check("div_m17_5_lat", 64'(lat), 64'd33);
      check("div_m17_5_q",   64'(lo_out), 64'h0000_0000_FFFF_FFFD);
      check("div_m17_5_r",   64'(hi_out), 64'h0000_0000_FFFF_FFFE);
      check("div_m17_5_dbz", 64'(div_by_zero), 64'd0);

      // 17 / -5 = -3 rem 2
      run_op(OP_DIV, 32'd17, 32'hFFFF_FFFB, 0, lat, busy_cnt, dbz0);
      check("div_17_m5_q", 64'(lo_out), 64'h0000_0000_FFFF_FFFD);
      check("div_17_m5_r", 64'(hi_out), 64'd2);

      // Divide by zero
      run_op(OP_DIV, 32'h0000_1234, 32'd0, 0, lat, busy_cnt, dbz0);
      check("dbz_lat",  64'(lat), 64'd1);
      check("dbz_busy", 64'(busy_cnt), 64'd1);
      check("dbz_flag", 64'(div_by_zero), 64'd1);
      check("dbz_hi",   64'(hi_out), 64'h0000_0000_0000_1234);
      check("dbz_lo",   64'(lo_out), 64'h0000_0000_FFFF_FFFF);

      // Overflow wrap with start pulsed during RUN
      pulses_before = done_pulses;
      run_op(OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 1, lat, busy_cnt, dbz0);
      check("ovf_dbz_cleared", 64'(dbz0), 64'd0);
      check("ovf_lat",    64'(lat), 64'd33);
      check("ovf_q",      64'(lo_out), 64'h0000_0000_8000_0000);
      check("ovf_r",      64'(hi_out), 64'd0);
      check("ovf_pulses", 64'(done_pulses - pulses_before), 64'd1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
